count_uart_reporter: RTL

//  Consumer end of the up/down counter output: watches the counter value Q_in and

---
 rtl/count_uart_reporter_if.sv | 28 ++
 rtl/count_uart_reporter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/count_uart_reporter_if.sv
// Bus between the up/down counter and its UART reporter. The counter side
// (master) drives the value and the resend request. The reporter side (slave)
// drives the serial line and the status flags.
interface count_uart_reporter_if #(
  parameter int NBITS = 4
);
  logic [NBITS-1:0] Q_in;
  logic             send_req;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (
    output Q_in,
    output send_req,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  Q_in,
    input  send_req,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/count_uart_reporter.sv
// Counter-value UART reporter.
// The block watches the counter value. When the value changes, or when a resend
// is requested, it sends the value as uppercase ASCII hex, most significant
// digit first, followed by CR and LF. The line format is 8N1.
// The value is captured when the report starts, so a report always carries a
// consistent value. Changes seen during a report are folded into at most one
// follow-up report.
module count_uart_reporter #(
  parameter int NBITS    = 4,
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic                   clk,
  input  logic                   nrst,
  count_uart_reporter_if.slave   bus
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int NDIG = (NBITS + 3) / 4;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [3:0]    CHR_CR   = 4'(NDIG);
  localparam logic [3:0]    CHR_LF   = 4'(NDIG + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       chr_q, chr_d;
  logic [NBITS-1:0] snap_q, snap_d;
  logic [NBITS-1:0] last_q, last_d;
  logic             pend_q, pend_d;
  logic             tx_q, tx_d;

  logic [4*NDIG-1:0] snap_ext;
  logic [3:0]        nib;
  logic [7:0]        cur_char;

  // Map the character index of the running report to its ASCII code.
  // Hex digits come first, MSB nibble first. CR and LF follow.
  always_comb begin
    snap_ext = '0;
    snap_ext[NBITS-1:0] = snap_q;
    nib      = 4'h0;
    cur_char = 8'h0A;
    if (chr_q < CHR_CR) begin
      nib = 4'(snap_ext >> (4 * (NDIG - 1 - int'(chr_q))));
      if (nib < 4'd10) begin
        cur_char = 8'h30 + {4'h0, nib};
      end else begin
        cur_char = 8'h37 + {4'h0, nib};
      end
    end else if (chr_q == CHR_CR) begin
      cur_char = 8'h0D;
    end
  end

  // Next-state logic for the framing FSM. The serial output is computed one
  // cycle ahead, so that tx leaves a flop without glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    snap_d  = snap_q;
    last_d  = last_q;
    pend_d  = pend_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if ((bus.Q_in != last_q) || bus.send_req || pend_q) begin
          snap_d  = bus.Q_in;
          last_d  = bus.Q_in;
          pend_d  = 1'b0;
          chr_d   = 4'd0;
          cnt_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = cur_char[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_d];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (chr_q == CHR_LF) begin
            state_d = S_IDLE;
          end else begin
            chr_d   = chr_q + 4'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A resend request that arrives during a report is remembered.
    // It is served when the FSM is back in IDLE.
    if ((state_q != S_IDLE) && bus.send_req) begin
      pend_d = 1'b1;
    end
  end

  // State and datapath registers. Reset aborts any frame and forces the line idle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      chr_q   <= 4'd0;
      snap_q  <= '0;
      last_q  <= '0;
      pend_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_STOP) && (chr_q == CHR_LF) && (cnt_q == CNT_LAST);

endmodule
